multi_serial_adder: RTL
=======================

Name: multi_serial_adder

Overview:
- Parametrised successor to the 4-input bit-serial adder.
- Sums NUM_IN operand streams; each stream delivers WORD_W-bit words LSB-first, one bit per accepted cycle.
- Emits the sum LSB-first, then flushes the carry bits, and presents the full-width parallel sum at word end.
- Adds word framing, valid/ready flow control with gaps, carry flush and sync-error detection; sits between serial front-end and word-level consumers.

Parameters:
NUM_IN, 4, number of serial operand streams (>=2)
WORD_W, 8, bits per operand word (>=2)
CW, $clog2(NUM_IN), carry register width and number of flush cycles (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_bits/in_first valid this cycle
in_first  input  1  marks bit 0 (LSB) of a word on all streams
in_bits  input  NUM_IN  one bit per stream, bit i = stream i
in_ready  output  1  block accepts an input bit this cycle
out_valid  output  1  out_bit valid this cycle
out_bit  output  1  serial sum bit, LSB-first
word_done  output  1  one-cycle pulse: last sum bit emitted, word_sum valid
word_sum  output  WORD_W+CW  parallel sum of the completed word
sync_err  output  1  one-cycle pulse on framing violation

Behaviour:
- Reset (rst=1 at edge): state IDLE; carry=0; bit_cnt=0; out_valid, out_bit, word_done, sync_err = 0; word_sum = 0; in_ready = 1 after reset. Reset wins over any simultaneous input; reset mid-word discards the partial word with no word_done.
- Accept = in_valid & in_ready.
- Column arithmetic on accept: s = popcount(in_bits) + carry (width CW+1 minimum). out_bit <= s[0]; carry <= s>>1. Carry never exceeds NUM_IN-1, so it fits in CW bits.
- Latency: out_bit/out_valid registered, 1 cycle after accept. out_valid=0 in any cycle following a cycle with no accept or flush.
- in_ready: combinational from state, 1 in IDLE/ACC, 0 in FLUSH.
- FSM IDLE:
  - accept with in_first=1: process as bit 0 with carry forced to 0; bit_cnt=1; go to ACC.
  - accept with in_first=0: bit dropped, no out_valid, sync_err pulse next cycle; stay IDLE.
- FSM ACC:
  - accept with in_first=0: process bit; bit_cnt++. When bit WORD_W-1 is processed, go to FLUSH.
  - accept with in_first=1: sync_err pulse; partial word abandoned (no word_done, word_sum unchanged); this bit is processed as bit 0 of a new word (carry forced 0, bit_cnt=1).
  - in_valid=0: hold all state (gaps allowed anywhere in the word).
- FSM FLUSH: CW cycles, no input accepted. Each cycle out_valid=1, out_bit=carry[0], carry>>=1. After the CW-th flush bit, go to IDLE.
- word_sum: emitted bits shift in at bit position = emit index. It updates and word_done pulses in the same cycle as the final (CW-th) flush out_valid. Value is held until the next word_done or reset.
- Per word: exactly WORD_W+CW out_valid cycles.
- Minimum word period: WORD_W+CW cycles. The next in_first is accepted in the cycle after FLUSH ends; in_first arriving while in_ready=0 is simply not accepted, because the source must hold it.

Test Plan:
- Reset, then NUM_IN=4, WORD_W=4, operands 1,2,3,4 (streams 0..3), no gaps, first accept cycle 0:
  - out_bit at cycles 1..6 = 0,1,0,1,0,0.
  - word_done at cycle 6; word_sum = 6'd10.
- All streams 4'hF: out bits 0,0,1,1,1,1; word_sum = 6'd60 (max carry path, carry=3 reached).
- Same 1,2,3,4 with in_valid low 2 cycles after bit 1 and 3 cycles after bit 2: identical bit sequence; exactly 6 out_valid cycles; word_sum = 10.
- Two back-to-back words (7,0,0,0 then 15,15,0,0):
  - in_ready=0 for 2 FLUSH cycles.
  - second in_first accepted the cycle after flush.
  - word_sum = 7, then 30.
- Framing errors:
  - in_valid with in_first=0 in IDLE -> sync_err pulse, no out_valid.
  - in_first during ACC at bit 2 -> sync_err; restarted word completes with the correct sum, and only one word_done occurs.
- rst asserted mid-ACC (bit 2 of 4):
  - next cycle: all outputs 0, in_ready=1, no word_done.
  - fresh word 3,3,3,3 -> word_sum = 12.

Source files
------------

// File: rtl/multi_serial_adder.sv
// multi_serial_adder
// Bit-serial adder for NUM_IN operand streams. Each stream delivers a
// WORD_W-bit word LSB-first, one bit per accepted cycle. The block emits the
// column sums LSB-first. It then flushes the remaining CW carry bits. When a
// word ends, it presents the full-width parallel sum.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_bits/in_first are valid this cycle
//   in_first   marks bit 0 of a word on all streams
//   in_bits    one bit per stream (bit i = stream i)
//   in_ready   block accepts an input bit this cycle (low while flushing)
//   out_valid  out_bit is valid this cycle
//   out_bit    serial sum bit, LSB-first
//   word_done  one-cycle pulse with the final flush bit; word_sum is valid
//   word_sum   parallel sum of the most recently completed word
//   sync_err   one-cycle pulse on a framing violation
module multi_serial_adder #(
  parameter int NUM_IN = 4,
  parameter int WORD_W = 8,
  localparam int CW = $clog2(NUM_IN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic [NUM_IN-1:0]    in_bits,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic                 out_bit,
  output logic                 word_done,
  output logic [WORD_W+CW-1:0] word_sum,
  output logic                 sync_err
);

  localparam int SUM_W = WORD_W + CW;
  localparam int COL_W = CW + 1;
  localparam int CNT_W = $clog2(SUM_W + 1);
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(SUM_W - 1);

  typedef enum logic [1:0] {IDLE, ACC, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_bit_q, out_bit_d;
  logic             word_done_q, word_done_d;
  logic             sync_err_q, sync_err_d;
  logic [SUM_W-1:0] shift_q, shift_d;
  logic [SUM_W-1:0] word_sum_q, word_sum_d;

  logic             accept;
  logic [CW-1:0]    carry_in;
  logic [COL_W-1:0] col_sum;

  assign in_ready = (state_q != FLUSH);
  assign accept   = in_valid & in_ready;

  // cnt_q counts emitted bit positions of the current word. It counts data
  // bits first and then flush bits, so one counter frames the whole word.
  // shift_q collects emitted bits from the top. After exactly SUM_W shifts,
  // bit k of shift_q is the bit emitted at index k. Bits left over from an
  // abandoned word are therefore always shifted out.
  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_bit_d   = 1'b0;
    word_done_d = 1'b0;
    sync_err_d  = 1'b0;
    shift_d     = shift_q;
    word_sum_d  = word_sum_q;

    // A word start always begins with a cleared carry.
    carry_in = in_first ? '0 : carry_q;
    col_sum  = COL_W'(carry_in);
    for (int i = 0; i < NUM_IN; i++) begin
      col_sum = col_sum + COL_W'(in_bits[i]);
    end

    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          if (in_first) begin
            // A start bit inside a word abandons the partial word.
            sync_err_d  = (state_q == ACC);
            out_valid_d = 1'b1;
            out_bit_d   = col_sum[0];
            carry_d     = col_sum[CW:1];
            shift_d     = {col_sum[0], shift_q[SUM_W-1:1]};
            cnt_d       = CNT_W'(1);
            state_d     = ACC;
          end else if (state_q == IDLE) begin
            sync_err_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_bit_d   = col_sum[0];
            carry_d     = col_sum[CW:1];
            shift_d     = {col_sum[0], shift_q[SUM_W-1:1]};
            cnt_d       = cnt_q + 1'b1;
            if (cnt_q == LAST_DATA) begin
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        out_valid_d = 1'b1;
        out_bit_d   = carry_q[0];
        carry_d     = carry_q >> 1;
        shift_d     = {carry_q[0], shift_q[SUM_W-1:1]};
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == LAST_FLUSH) begin
          state_d     = IDLE;
          cnt_d       = '0;
          word_done_d = 1'b1;
          word_sum_d  = shift_d;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      carry_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      word_done_q <= 1'b0;
      sync_err_q  <= 1'b0;
      shift_q     <= '0;
      word_sum_q  <= '0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      word_done_q <= word_done_d;
      sync_err_q  <= sync_err_d;
      shift_q     <= shift_d;
      word_sum_q  <= word_sum_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign word_done = word_done_q;
  assign sync_err  = sync_err_q;
  assign word_sum  = word_sum_q;

endmodule
